// File: rtl/mem_responder.sv
// mem_responder: en/we memory target with post-reset clear, latency pipeline, counters, error flag
// Ports: clk, rst (async, active high); add/dataW/en/we carry one access per cycle;
//        dataR/rd_valid return read data after RD_LATENCY; init_done marks memory ready;
//        err is sticky on any access before ready; wr_cnt/rd_cnt are saturating access counts.
// Macro MEM_RESPONDER_INIT_EN: when defined, INIT zero-fills every word (DEPTH cycles);
//        otherwise INIT lasts one cycle and contents stay undefined until written.
module mem_responder #(
    parameter int ADD_WIDTH  = 10,
    parameter int DAT_WIDTH  = 8,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADD_WIDTH-1:0] add,
    input  logic [DAT_WIDTH-1:0] dataW,
    output logic [DAT_WIDTH-1:0] dataR,
    input  logic                 en,
    input  logic                 we,
    output logic                 rd_valid,
    output logic                 init_done,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] wr_cnt,
    output logic [CNT_WIDTH-1:0] rd_cnt
);
    localparam int DEPTH = 1 << ADD_WIDTH;

    typedef enum logic {INIT, IDLE} state_t;

    state_t               state, state_n;
    logic [DAT_WIDTH-1:0] mem [DEPTH];
    logic [ADD_WIDTH-1:0] ptr;
    logic                 clr, last, wr, rd, fin_v;
    logic [DAT_WIDTH-1:0] fin_d;

`ifdef MEM_RESPONDER_INIT_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= '0;
        else if (state == INIT) ptr <= ptr + ADD_WIDTH'(1);
    // rst gating keeps the clear sequence from touching memory while reset is held
    assign clr  = (state == INIT) && !rst;
    assign last = &ptr;
`else
    assign ptr  = '0;
    assign clr  = 1'b0;
    assign last = 1'b1;
`endif

    always_comb begin
        state_n = state;
        wr      = 1'b0;
        rd      = 1'b0;
        if (state == INIT) state_n = last ? IDLE : INIT;
        else begin
            wr = en && we;
            rd = en && !we;
        end
    end

    always_ff @(posedge clk)
        if (clr) mem[ptr] <= '0;
        else if (wr) mem[add] <= dataW;

    // Stage 0 of the read path is the edge that samples the request; RD_LATENCY-1 more
    // registers follow before dataR is loaded.
    generate
        if (RD_LATENCY == 1) begin : g_direct
            assign fin_v = rd;
            assign fin_d = mem[add];
        end else begin : g_pipe
            logic [RD_LATENCY-2:0] sv;
            logic [DAT_WIDTH-1:0]  sd [RD_LATENCY-1];
            always_ff @(posedge clk or posedge rst)
                if (rst) sv <= '0;
                else begin
                    sv[0] <= rd;
                    for (int i = 1; i < RD_LATENCY - 1; i++) sv[i] <= sv[i-1];
                end
            always_ff @(posedge clk) begin
                sd[0] <= mem[add];
                for (int i = 1; i < RD_LATENCY - 1; i++) sd[i] <= sd[i-1];
            end
            assign fin_v = sv[RD_LATENCY-2];
            assign fin_d = sd[RD_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= INIT;
            dataR    <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
        end else begin
            state    <= state_n;
            rd_valid <= fin_v;
            if (fin_v) dataR <= fin_d;
            if (state == INIT && en) err <= 1'b1;
            if (wr && !(&wr_cnt)) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
            if (rd && !(&rd_cnt)) rd_cnt <= rd_cnt + CNT_WIDTH'(1);
        end

    assign init_done = state == IDLE;
endmodule
